// File: rtl/pulse_sched_if.sv
// Request/response bundle between the pulse requesters and pulse_sched.
// Latency: none (signal bundle only).
// Backpressure: requesters hold req level until their done strobe.
//
// Signals: req (level request per channel), width (16-bit length per channel,
// channel i at [16*i+15:16*i]), grant/pulse_out/done (per channel), busy,
// and aborted when PULSE_SCHED_ABORT_EN is defined.
// master = requester side, slave = scheduler side.
interface pulse_sched_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    req;
    logic [16*NUM_CH-1:0] width;
    logic [NUM_CH-1:0]    grant;
    logic [NUM_CH-1:0]    pulse_out;
    logic [NUM_CH-1:0]    done;
    logic                 busy;
`ifdef PULSE_SCHED_ABORT_EN
    logic                 aborted;

    modport master (output req, width, input grant, pulse_out, done, busy, aborted);
    modport slave  (input req, width, output grant, pulse_out, done, busy, aborted);
`else
    modport master (output req, width, input grant, pulse_out, done, busy);
    modport slave  (input req, width, output grant, pulse_out, done, busy);
`endif
endinterface

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one 16-bit one-shot pulse timer across NUM_CH channels.
// Latency: pulse starts 1 edge after req is seen in IDLE; done on the edge the pulse ends.
// Backpressure: pending requesters wait (req held) while a pulse or the idle gap runs.
//
// Ports: clk, resetn (async assert, active-low, release synchronized internally),
//        bus (pulse_sched_if.slave): req, width in; grant, pulse_out, done, busy out.
// Optional: define PULSE_SCHED_ABORT_EN to end a pulse early when its req drops,
//           flagged on bus.aborted alongside done.
module pulse_sched #(
    parameter int NUM_CH     = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         resetn,
    pulse_sched_if.slave bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    // The done edge itself counts as the first gap cycle's entry, hence -1.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t             state_q, state_n;
    logic [15:0]        cnt_q, cnt_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [IDX_W-1:0]   win_q, win_n;
    logic [IDX_W-1:0]   prio_q, prio_n;     // highest-priority channel for next arbitration
    logic [NUM_CH-1:0]  grant_q, grant_n;
    logic [NUM_CH-1:0]  pulse_q, pulse_n;
    logic [NUM_CH-1:0]  done_q, done_n;
    logic               busy_q, busy_n;
    logic [1:0]         rst_sync_q;
`ifdef PULSE_SCHED_ABORT_EN
    logic               aborted_q, aborted_n;
`endif

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [15:0]        pick_width;
    logic               end_run;
    int                 k;

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] c);
        return (c == IDX_W'(NUM_CH - 1)) ? '0 : c + IDX_W'(1);
    endfunction

    // Release edge is synchronized; requests are only honoured once it has
    // propagated through both stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            win_q     <= '0;
            prio_q    <= '0;
            grant_q   <= '0;
            pulse_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
`ifdef PULSE_SCHED_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            gap_q     <= gap_n;
            win_q     <= win_n;
            prio_q    <= prio_n;
            grant_q   <= grant_n;
            pulse_q   <= pulse_n;
            done_q    <= done_n;
            busy_q    <= busy_n;
`ifdef PULSE_SCHED_ABORT_EN
            aborted_q <= aborted_n;
`endif
        end
    end

    always_comb begin
        // Rotated search: walk from lowest to highest priority so the last
        // hit (closest to prio_q) wins.
        found = 1'b0;
        pick  = '0;
        k     = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = int'(prio_q) + i;
            if (k >= NUM_CH) k = k - NUM_CH;
            if (bus.req[k]) begin
                found = 1'b1;
                pick  = IDX_W'(k);
            end
        end
        pick_width = bus.width[16*int'(pick) +: 16];

        state_n = state_q;
        cnt_n   = cnt_q;
        gap_n   = gap_q;
        win_n   = win_q;
        prio_n  = prio_q;
        grant_n = grant_q;
        pulse_n = pulse_q;
        done_n  = '0;
        end_run = 1'b0;
`ifdef PULSE_SCHED_ABORT_EN
        aborted_n = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (rst_sync_q[1] && found) begin
                    win_n = pick;
                    cnt_n = pick_width;
                    if (pick_width != 16'd0) begin
                        grant_n = NUM_CH'(1) << pick;
                        pulse_n = NUM_CH'(1) << pick;
                        state_n = RUN;
                    end else begin
                        // Zero-length request completes immediately without a pulse.
                        done_n  = NUM_CH'(1) << pick;
                        prio_n  = nxt(pick);
                        gap_n   = GAP_LOAD;
                        state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end
                end
            end
            RUN: begin
                // cnt_q holds the cycles still to run including this one.
                if (cnt_q <= 16'd1) begin
                    end_run = 1'b1;
`ifdef PULSE_SCHED_ABORT_EN
                end else if (!bus.req[win_q]) begin
                    end_run   = 1'b1;
                    aborted_n = 1'b1;
`endif
                end
                if (cnt_q != 16'd0) cnt_n = cnt_q - 16'd1;
                if (end_run) begin
                    grant_n = '0;
                    pulse_n = '0;
                    done_n  = NUM_CH'(1) << win_q;
                    prio_n  = nxt(win_q);
                    gap_n   = GAP_LOAD;
                    state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == '0) state_n = IDLE;
                else             gap_n   = gap_q - GAP_W'(1);
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.grant     = grant_q;
    assign bus.pulse_out = pulse_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
`ifdef PULSE_SCHED_ABORT_EN
    assign bus.aborted   = aborted_q;
`endif
endmodule
